gg_slice_rowslice_writer: RTL and testbench

Row-slice header and slice-data framing generator for the encoder's output bitstream. It emits `slice_layer_rbsp()` symbols in order:
- the fixed-profile P-slice header;
- one `mb_skip_run` ue(v) before each coded macroblock, passing that macroblock's payload symbols through;
- the slice-end skip run and `rbsp_trailing_bits`.

It sits between the macroblock writer and the downstream bit packer. Its syntax order is exactly what the row-slice lattice parser consumes.

---
 rtl/gg_slice_rowslice_writer_pkg.sv | 45 ++++
 rtl/gg_slice_rowslice_writer_if.sv | 68 ++++++
 rtl/gg_slice_rowslice_writer_expgolomb.sv | 32 +++
 rtl/gg_slice_rowslice_writer.sv | 229 ++++++++++++++++++++++
 tb/tb_gg_slice_rowslice_writer.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gg_slice_rowslice_writer_pkg.sv
// Shared types for the row-slice header/skip-run writer.
// Build option GG_SLICE_DBLK_OFFSET_EN: emit alpha/beta from ports.
package gg_slice_pkg;

  localparam int SYM_W = 32;
  localparam int FRAME_NUM_BITS_DEF = 4;
  localparam int POC_LSB_BITS_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SKIP,
    S_MB,
    S_TRAIL
  } state_t;

  typedef enum logic [3:0] {
    F_FIRST_MB   = 4'd0,
    F_SLICE_TYPE = 4'd1,
    F_PPS_ID     = 4'd2,
    F_FRAME_NUM  = 4'd3,
    F_POC_LSB    = 4'd4,
    F_FLAGS      = 4'd5,
    F_QP_DELTA   = 4'd6,
    F_DBLK_IDC   = 4'd7,
    F_ALPHA      = 4'd8,
    F_BETA       = 4'd9,
    F_END        = 4'd10
  } fld_t;

  typedef struct packed {
    logic [SYM_W-1:0] bits;
    logic [5:0]       len;
  } sym_t;

  // stop bit then zeros up to the next byte boundary
  function automatic sym_t trail_sym(input logic [2:0] bp);
    sym_t s;
    s.bits = '0;
    s.bits[3'd7 - bp] = 1'b1;
    s.len = 6'd8 - {3'd0, bp};
    return s;
  endfunction

endpackage

// File: rtl/gg_slice_rowslice_writer_if.sv
// Command, payload and symbol-output bundle of the row-slice writer.
// master drives commands/payload; slave is the writer.
interface gg_slice_rowslice_writer_if #(
  parameter int WIDTH = 32,
  parameter int FRAME_NUM_BITS = 4,
  parameter int POC_LSB_BITS = 4
) ();

  logic                      slice_start;
  logic [12:0]               first_mb;
  logic [2:0]                slice_type;
  logic [7:0]                pps_id;
  logic [FRAME_NUM_BITS-1:0] frame_num;
  logic [POC_LSB_BITS-1:0]   poc_lsb;
  logic [6:0]                qp_delta;
  logic [1:0]                dblk_idc;
  logic [3:0]                dblk_alpha;
  logic [3:0]                dblk_beta;

  logic                      mb_valid;
  logic                      mb_ready;
  logic [14:0]               mb_skip;

  logic                      mbsym_valid;
  logic                      mbsym_ready;
  logic [WIDTH-1:0]          mbsym_bits;
  logic [5:0]                mbsym_len;
  logic                      mbsym_last;

  logic                      end_valid;
  logic                      end_ready;
  logic [14:0]               end_skip;

  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_bits;
  logic [5:0]                out_len;

  logic                      slice_busy;
  logic                      slice_end;

  modport master (
    output slice_start, first_mb, slice_type, pps_id,
    output frame_num, poc_lsb, qp_delta,
    output dblk_idc, dblk_alpha, dblk_beta,
    output mb_valid, mb_skip,
    output mbsym_valid, mbsym_bits, mbsym_len, mbsym_last,
    output end_valid, end_skip,
    output out_ready,
    input  mb_ready, mbsym_ready, end_ready,
    input  out_valid, out_bits, out_len,
    input  slice_busy, slice_end
  );

  modport slave (
    input  slice_start, first_mb, slice_type, pps_id,
    input  frame_num, poc_lsb, qp_delta,
    input  dblk_idc, dblk_alpha, dblk_beta,
    input  mb_valid, mb_skip,
    input  mbsym_valid, mbsym_bits, mbsym_len, mbsym_last,
    input  end_valid, end_skip,
    input  out_ready,
    output mb_ready, mbsym_ready, end_ready,
    output out_valid, out_bits, out_len,
    output slice_busy, slice_end
  );

endinterface

// File: rtl/gg_slice_rowslice_writer_expgolomb.sv
// Combinational Exp-Golomb encoder: ue(v) or se(k) of a 16-bit value.
// Leading zeros are implicit in the right-aligned symbol.
module gg_expgolomb_enc
  import gg_slice_pkg::*;
(
  input  logic [15:0] val,
  input  logic        se,
  output sym_t        sym
);

  logic [17:0] code;
  logic [16:0] neg;
  logic [4:0]  msb;

  always_comb begin
    neg  = 17'd0 - {val[15], val};
    code = 18'(val) + 18'd1;
    if (se) begin
      // code = codeNum + 1: 2k for k>0, -2k+1 otherwise
      if (!val[15] && val != 16'd0)
        code = {1'b0, val, 1'b0};
      else
        code = {neg, 1'b1};
    end
    msb = '0;
    for (int i = 0; i < 18; i++)
      if (code[i]) msb = 5'(i);
    sym.bits = SYM_W'(code);
    sym.len  = 6'({msb, 1'b0}) + 6'd1;
  end

endmodule

// File: rtl/gg_slice_rowslice_writer.sv
// Row-slice writer: P-slice header, mb_skip_run framing, trailing bits.
// GG_SLICE_DBLK_OFFSET_EN: alpha/beta from ports, else se(0).
module gg_slice_rowslice_writer
  import gg_slice_pkg::*;
#(
  parameter int WIDTH = SYM_W,
  parameter int FRAME_NUM_BITS = FRAME_NUM_BITS_DEF,
  parameter int POC_LSB_BITS = POC_LSB_BITS_DEF
) (
  input logic clk,
  input logic reset,
  gg_slice_rowslice_writer_if.slave bus
);

  state_t state, state_nxt;
  fld_t   fld;

  logic             out_vq;
  logic [WIDTH-1:0] out_bq;
  logic [5:0]       out_lq;
  logic [2:0]       bitpos, bp_nxt;
  logic             prev_hdr, trail_sent;

  logic [2:0]                type_q;
  logic [7:0]                pps_q;
  logic [FRAME_NUM_BITS-1:0] fn_q;
  logic [POC_LSB_BITS-1:0]   poc_q;
  logic [6:0]                qp_q;
  logic [1:0]                idc_q;
`ifdef GG_SLICE_DBLK_OFFSET_EN
  logic [3:0]                alpha_q, beta_q;
`else
  logic                      unused_dblk;
  assign unused_dblk = ^{bus.dblk_alpha, bus.dblk_beta};
`endif

  logic pass, out_fire, q_fire, slot_free;
  logic last_hs, cmd_slot, start_acc;
  logic hdr_load, hdr_last, mb_acc, end_acc;
  logic end_emit, trail_load, trail_done, ld;

  logic [15:0] enc_val;
  logic        enc_se;
  sym_t        enc_sym, hdr_sym, trl_sym, ld_sym;

  // payload passes through once the queued skip symbol has gone
  assign pass = state == S_MB && !out_vq;

  assign bus.out_valid   = pass ? bus.mbsym_valid : out_vq;
  assign bus.out_bits    = pass ? bus.mbsym_bits : out_bq;
  assign bus.out_len     = pass ? bus.mbsym_len : out_lq;
  assign bus.mbsym_ready = pass && bus.out_ready;

  assign out_fire  = bus.out_valid && bus.out_ready;
  assign q_fire    = out_vq && bus.out_ready;
  assign slot_free = !out_vq || bus.out_ready;

  assign last_hs = pass && bus.mbsym_valid
                && bus.out_ready && bus.mbsym_last;
  assign cmd_slot = (state == S_SKIP && slot_free)
                 || last_hs;

  assign bus.mb_ready  = cmd_slot;
  assign bus.end_ready = cmd_slot && !bus.mb_valid;

  assign start_acc = state == S_IDLE && bus.slice_start;
  assign hdr_load  = state == S_HDR && slot_free;
  assign hdr_last  = (fld == F_DBLK_IDC && idc_q == 2'd1)
                  || fld == F_BETA;
  assign mb_acc    = cmd_slot && bus.mb_valid;
  assign end_acc   = cmd_slot && !bus.mb_valid
                  && bus.end_valid;
  assign end_emit  = end_acc
                  && (prev_hdr || bus.end_skip != 15'd0);
  assign trail_load = state == S_TRAIL && !trail_sent
                   && slot_free;
  assign trail_done = state == S_TRAIL && trail_sent
                   && q_fire;

  assign bus.slice_end  = trail_done;
  assign bus.slice_busy = state != S_IDLE;

  assign bp_nxt  = bitpos
                 + (out_fire ? bus.out_len[2:0] : 3'd0);
  assign trl_sym = trail_sym(bp_nxt);

  always_comb begin
    enc_val = '0;
    enc_se  = 1'b0;
    unique case (1'b1)
      state == S_IDLE: enc_val = {3'd0, bus.first_mb};
      state == S_HDR: begin
        case (fld)
          F_SLICE_TYPE: enc_val = {13'd0, type_q};
          F_PPS_ID:     enc_val = {8'd0, pps_q};
          F_QP_DELTA: begin
            enc_val = {{9{qp_q[6]}}, qp_q};
            enc_se  = 1'b1;
          end
          F_DBLK_IDC:   enc_val = {14'd0, idc_q};
`ifdef GG_SLICE_DBLK_OFFSET_EN
          F_ALPHA: begin
            enc_val = {{12{alpha_q[3]}}, alpha_q};
            enc_se  = 1'b1;
          end
          F_BETA: begin
            enc_val = {{12{beta_q[3]}}, beta_q};
            enc_se  = 1'b1;
          end
`else
          F_ALPHA, F_BETA: enc_se = 1'b1;
`endif
          default: ;
        endcase
      end
      default: enc_val = bus.mb_valid
                       ? {1'b0, bus.mb_skip}
                       : {1'b0, bus.end_skip};
    endcase
  end

  gg_expgolomb_enc u_enc (
    .val (enc_val),
    .se  (enc_se),
    .sym (enc_sym)
  );

  always_comb begin
    hdr_sym = enc_sym;
    case (fld)
      F_FRAME_NUM: begin
        hdr_sym.bits = SYM_W'(fn_q);
        hdr_sym.len  = 6'(FRAME_NUM_BITS);
      end
      F_POC_LSB: begin
        hdr_sym.bits = SYM_W'(poc_q);
        hdr_sym.len  = 6'(POC_LSB_BITS);
      end
      F_FLAGS: begin
        hdr_sym.bits = '0;
        hdr_sym.len  = 6'd3;
      end
      default: ;
    endcase
  end

  assign ld = start_acc || hdr_load || mb_acc
           || end_emit || trail_load;

  always_comb begin
    ld_sym = enc_sym;
    unique case (1'b1)
      trail_load: ld_sym = trl_sym;
      hdr_load:   ld_sym = hdr_sym;
      default:    ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_acc) state_nxt = S_HDR;
      S_HDR:   if (hdr_load && hdr_last) state_nxt = S_SKIP;
      S_SKIP, S_MB: begin
        if (mb_acc)       state_nxt = S_MB;
        else if (end_acc) state_nxt = S_TRAIL;
        else if (last_hs) state_nxt = S_SKIP;
      end
      S_TRAIL: if (trail_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vq     <= 1'b0;
      out_bq     <= '0;
      out_lq     <= '0;
      bitpos     <= '0;
      fld        <= F_FIRST_MB;
      prev_hdr   <= 1'b0;
      trail_sent <= 1'b0;
      type_q     <= '0;
      pps_q      <= '0;
      fn_q       <= '0;
      poc_q      <= '0;
      qp_q       <= '0;
      idc_q      <= '0;
`ifdef GG_SLICE_DBLK_OFFSET_EN
      alpha_q    <= '0;
      beta_q     <= '0;
`endif
    end else begin
      bitpos <= start_acc ? 3'd0 : bp_nxt;
      if (q_fire) out_vq <= 1'b0;
      if (ld) begin
        out_vq <= 1'b1;
        out_bq <= WIDTH'(ld_sym.bits);
        out_lq <= ld_sym.len;
      end
      if (start_acc) begin
        fld        <= F_SLICE_TYPE;
        prev_hdr   <= 1'b1;
        trail_sent <= 1'b0;
        type_q     <= bus.slice_type;
        pps_q      <= bus.pps_id;
        fn_q       <= bus.frame_num;
        poc_q      <= bus.poc_lsb;
        qp_q       <= bus.qp_delta;
        idc_q      <= bus.dblk_idc == 2'd3
                    ? 2'd0 : bus.dblk_idc;
`ifdef GG_SLICE_DBLK_OFFSET_EN
        alpha_q    <= bus.dblk_alpha;
        beta_q     <= bus.dblk_beta;
`endif
      end
      if (hdr_load) fld <= fld_t'(fld + 4'd1);
      if (mb_acc) prev_hdr <= 1'b0;
      if (trail_load) trail_sent <= 1'b1;
      if (trail_done) trail_sent <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gg_slice_rowslice_writer.sv
// Scoreboard bench for gg_slice_rowslice_writer.
// Expected symbols are queued as stimulus is driven.
module tb_gg_slice_rowslice_writer;

  localparam int W   = 32;
  localparam int FNB = 4;
  localparam int PLB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gg_slice_rowslice_writer_if #(
    .WIDTH(W), .FRAME_NUM_BITS(FNB), .POC_LSB_BITS(PLB)
  ) bus ();

  gg_slice_rowslice_writer #(
    .WIDTH(W), .FRAME_NUM_BITS(FNB), .POC_LSB_BITS(PLB)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] bits;
    logic [5:0]  len;
    logic        last;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   tot_bits = 0;
  int   end_cnt = 0;
  int   exp_ends = 0;
  int   last_trail_len = 0;
  bit   prev_hdr_m = 0;
  bit   bp_en = 0;
  bit   stall_prev = 0;
  logic [31:0] stall_bits;
  logic [5:0]  stall_len;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic exp_t ue(input int unsigned v);
    exp_t e;
    int unsigned code;
    int n;
    code = v + 1;
    n = 0;
    while ((code >> (n + 1)) != 0) n++;
    e.bits = 32'(code);
    e.len  = 6'(2 * n + 1);
    e.last = 1'b0;
    return e;
  endfunction

  function automatic exp_t se(input int k);
    return ue(k > 0 ? 2 * k - 1 : -2 * k);
  endfunction

  function automatic exp_t lit(input int unsigned b,
                               input int l);
    exp_t e;
    e.bits = 32'(b);
    e.len  = 6'(l);
    e.last = 1'b0;
    return e;
  endfunction

  task automatic push(input exp_t e);
    q.push_back(e);
    tot_bits += int'(e.len);
  endtask

  // monitor: compare each accepted symbol, check stall stability
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (stall_prev) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_bits", 64'(bus.out_bits),
            64'(stall_bits));
        chk("stall_len", 64'(bus.out_len), 64'(stall_len));
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_bits = bus.out_bits;
      stall_len  = bus.out_len;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("extra_sym", 64'(q.size()), 64'd1);
        end else begin
          mon_e = q.pop_front();
          chk("bits", 64'(bus.out_bits), 64'(mon_e.bits));
          chk("len", 64'(bus.out_len), 64'(mon_e.len));
          chk("end_pulse", 64'(bus.slice_end),
              64'(mon_e.last));
          if (mon_e.last) last_trail_len = int'(bus.out_len);
        end
      end
      if (bus.slice_end) end_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (bp_en) bus.out_ready = ~bus.out_ready;
  end

  task automatic wait_rdy(input int sel);
    int cyc;
    bit r;
    cyc = 0;
    r = 1'b0;
    while (!r && cyc < 300) begin
      @(negedge clk);
      case (sel)
        0:       r = bus.mb_ready;
        1:       r = bus.end_ready;
        default: r = bus.mbsym_ready;
      endcase
      cyc++;
    end
    if (!r) chk("hs_timeout", 64'(r), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic push_hdr(input int fm, input int ty,
                          input int pps, input int fn,
                          input int poc, input int qp,
                          input int idc, input int a,
                          input int b);
    tot_bits = 0;
    prev_hdr_m = 1'b1;
    push(ue(fm));
    push(ue(ty));
    push(ue(pps));
    push(lit(fn, FNB));
    push(lit(poc, PLB));
    push(lit(0, 3));
    push(se(qp));
    push(ue(idc == 3 ? 0 : idc));
    if (idc != 1) begin
`ifdef GG_SLICE_DBLK_OFFSET_EN
      push(se(a));
      push(se(b));
`else
      if (a != b || a == b) begin
        push(lit(1, 1));
        push(lit(1, 1));
      end
`endif
    end
  endtask

  task automatic start_drive(input int fm, input int ty,
                             input int pps, input int fn,
                             input int poc, input int qp,
                             input int idc, input int a,
                             input int b);
    bus.first_mb    = 13'(fm);
    bus.slice_type  = 3'(ty);
    bus.pps_id      = 8'(pps);
    bus.frame_num   = FNB'(fn);
    bus.poc_lsb     = PLB'(poc);
    bus.qp_delta    = 7'(qp);
    bus.dblk_idc    = 2'(idc);
    bus.dblk_alpha  = 4'(a);
    bus.dblk_beta   = 4'(b);
    bus.slice_start = 1'b1;
    @(posedge clk);
    #1;
    bus.slice_start = 1'b0;
    chk("first_valid", 64'(bus.out_valid), 64'd1);
    chk("busy_set", 64'(bus.slice_busy), 64'd1);
  endtask

  task automatic start(input int fm, input int ty,
                       input int pps, input int fn,
                       input int poc, input int qp,
                       input int idc, input int a,
                       input int b);
    push_hdr(fm, ty, pps, fn, poc, qp, idc, a, b);
    start_drive(fm, ty, pps, fn, poc, qp, idc, a, b);
  endtask

  task automatic mb_cmd(input int skip);
    push(ue(skip));
    prev_hdr_m = 1'b0;
    bus.mb_skip  = 15'(skip);
    bus.mb_valid = 1'b1;
    wait_rdy(0);
    bus.mb_valid = 1'b0;
  endtask

  task automatic payload(input int len, input bit last);
    exp_t e;
    logic [31:0] mask;
    mask = (len >= 32) ? 32'hffff_ffff
                       : (32'd1 << len) - 32'd1;
    e.bits = $urandom & mask;
    e.len  = 6'(len);
    e.last = 1'b0;
    push(e);
    bus.mbsym_bits  = e.bits;
    bus.mbsym_len   = 6'(len);
    bus.mbsym_last  = last;
    bus.mbsym_valid = 1'b1;
    wait_rdy(2);
    bus.mbsym_valid = 1'b0;
    bus.mbsym_last  = 1'b0;
  endtask

  task automatic end_cmd(input int skip);
    exp_t t;
    int cyc;
    if (prev_hdr_m || skip > 0) push(ue(skip));
    t.len  = 6'(8 - tot_bits % 8);
    t.bits = 32'd1 << (t.len - 6'd1);
    t.last = 1'b1;
    push(t);
    exp_ends++;
    bus.end_skip  = 15'(skip);
    bus.end_valid = 1'b1;
    wait_rdy(1);
    bus.end_valid = 1'b0;
    cyc = 0;
    while (bus.slice_busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("busy_clear", 64'(bus.slice_busy), 64'd0);
    chk("drain", 64'(q.size()), 64'd0);
    chk("end_cnt", 64'(end_cnt), 64'(exp_ends));
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({pfx, "_mb_ready"}, 64'(bus.mb_ready), 64'd0);
    chk({pfx, "_end_ready"}, 64'(bus.end_ready), 64'd0);
    chk({pfx, "_mbsym_rdy"}, 64'(bus.mbsym_ready), 64'd0);
    chk({pfx, "_busy"}, 64'(bus.slice_busy), 64'd0);
    chk({pfx, "_slice_end"}, 64'(bus.slice_end), 64'd0);
    chk({pfx, "_out_bits"}, 64'(bus.out_bits), 64'd0);
    chk({pfx, "_out_len"}, 64'(bus.out_len), 64'd0);
  endtask

  task automatic two_mb;
    start(5, 0, 1, 9, 2, 4, 1, 0, 0);
    mb_cmd(0);
    for (int i = 0; i < 3; i++) payload(7 + i * 5, i == 2);
    mb_cmd(2);
    for (int i = 0; i < 3; i++) payload(3 + i, i == 2);
    end_cmd(0);
  endtask

  initial begin
    int p;
    bus.slice_start = 0; bus.first_mb = 0;
    bus.slice_type = 0;  bus.pps_id = 0;
    bus.frame_num = 0;   bus.poc_lsb = 0;
    bus.qp_delta = 0;    bus.dblk_idc = 0;
    bus.dblk_alpha = 0;  bus.dblk_beta = 0;
    bus.mb_valid = 0;    bus.mb_skip = 0;
    bus.mbsym_valid = 0; bus.mbsym_bits = 0;
    bus.mbsym_len = 0;   bus.mbsym_last = 0;
    bus.end_valid = 0;   bus.end_skip = 0;
    bus.out_ready = 1;
    #2;
    check_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // empty slice, literal expectations
    tot_bits = 0;
    prev_hdr_m = 1'b1;
    push(lit(1, 1)); push(lit(1, 1)); push(lit(1, 1));
    push(lit(4'b0011, 4)); push(lit(4'b0110, 4));
    push(lit(0, 3)); push(lit(5'b00101, 5));
    push(lit(3'b010, 3));
    start_drive(0, 0, 0, 3, 6, -2, 1, 0, 0);
    end_cmd(5);
    chk("empty_trail", 64'(last_trail_len), 64'd5);

    // deblocking offsets present
    start(37, 5, 2, 1, 7, 3, 0, 1, -1);
    mb_cmd(0);
    payload(9, 0);
    payload(4, 1);
    end_cmd(0);

    // unknown idc treated as 0
    start(100, 2, 200, 15, 0, -64, 3, -8, 7);
    end_cmd(0);

    two_mb();

    bp_en = 1'b1;
    two_mb();
    start(1, 1, 3, 4, 5, -7, 0, 3, -4);
    mb_cmd(40);
    payload(31, 1);
    end_cmd(12);
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // reset in the middle of a macroblock payload
    start(3, 0, 0, 1, 1, 0, 1, 0, 0);
    mb_cmd(1);
    payload(5, 0);
    payload(7, 0);
    @(negedge clk);
    chk("pre_rst_busy", 64'(bus.slice_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    q.delete();
    chk("no_end_on_rst", 64'(end_cnt), 64'(exp_ends));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start(2, 0, 1, 6, 3, 1, 1, 0, 0);
    mb_cmd(0);
    payload(6, 1);
    end_cmd(3);

    // trailing length for every final bit position
    for (int t = 0; t < 8; t++) begin
      start(0, 0, 0, 0, 0, 0, 1, 0, 0);
      mb_cmd(0);
      p = ((t - tot_bits) % 8 + 8) % 8;
      if (p == 0) p = 8;
      payload(p, 1);
      end_cmd(0);
      chk($sformatf("trail_len_%0d", t),
          64'(last_trail_len), 64'(8 - t));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
